// File: rtl/ma_stage_pkg.sv
// Shared definitions for the memory-access stage: one-hot load/store bit
// positions, the request FSM encoding and the latched instruction record.
// Imported by ma_store_align and ma_stage.
package ma_stage_pkg;

    localparam int LOAD_W  = 7;
    localparam int STORE_W = 5;

    // align_load one-hot bit positions, MSB first: {lw,lb,lbu,lh,lhu,lwl,lwr}
    localparam int LD_LW  = 6;
    localparam int LD_LB  = 5;
    localparam int LD_LBU = 4;
    localparam int LD_LH  = 3;
    localparam int LD_LHU = 2;
    localparam int LD_LWL = 1;
    localparam int LD_LWR = 0;

    // align_store one-hot bit positions, MSB first: {sw,sb,sh,swl,swr}
    localparam int ST_SW  = 4;
    localparam int ST_SB  = 3;
    localparam int ST_SH  = 2;
    localparam int ST_SWL = 1;
    localparam int ST_SWR = 0;

    typedef enum logic {
        MA_IDLE = 1'b0,   // no request in flight
        MA_REQ  = 1'b1    // request asserted, waiting for data_addr_ok
    } ma_state_e;

    // Everything captured from EX on the input handshake.
    typedef struct packed {
        logic [31:0]        pc;
        logic [31:0]        rf_b;
        logic [31:0]        alu_res;
        logic [4:0]         rf_waddr;
        logic [2:0]         rf_wdata_src;
        logic               rf_wen;
        logic               mem_read;
        logic [LOAD_W-1:0]  align_load;
        logic               mem_write;
        logic [STORE_W-1:0] align_store;
    } ma_inst_t;

    // Loads and stores always address the containing word.
    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ma_stage_if.sv
// Data-interlayer request channel between MA (master) and the interlayer (slave).
// Latency: none, wires only. Backpressure: the request holds until data_addr_ok.
// Signals: data_req/data_wr/data_wstrb/data_addr/data_wdata out of MA, data_addr_ok back.
interface ma_stage_if;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;

    modport master (
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok
    );

    modport slave (
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok
    );

endinterface

// File: rtl/ma_store_align.sv
// Store byte-lane alignment: turns store type + address low bits into strobes and lane data.
// Latency: purely combinational.
// Backpressure: none; no handshake.
// Ports: align_store (one-hot {sw,sb,sh,swl,swr}), a (addr[1:0]), b (register B) -> wstrb, wdata.
module ma_store_align
    import ma_stage_pkg::*;
(
    input  logic [STORE_W-1:0] align_store,
    input  logic [1:0]         a,
    input  logic [31:0]        b,
    output logic [3:0]         wstrb,
    output logic [31:0]        wdata
);

    always_comb begin
        wstrb = 4'b0000;
        wdata = 32'h0;
        if (align_store[ST_SW]) begin
            wstrb = 4'b1111;
            wdata = b;
        end else if (align_store[ST_SB]) begin
            wstrb = 4'b0001 << a;
            wdata = {4{b[7:0]}};
        end else if (align_store[ST_SH]) begin
            wstrb = a[1] ? 4'b1100 : 4'b0011;
            wdata = {2{b[15:0]}};
        end else if (align_store[ST_SWL]) begin
            // swl writes the high-order bytes of B into the low lanes up to a
            case (a)
                2'd0:    begin wstrb = 4'b0001; wdata = b >> 24; end
                2'd1:    begin wstrb = 4'b0011; wdata = b >> 16; end
                2'd2:    begin wstrb = 4'b0111; wdata = b >> 8;  end
                default: begin wstrb = 4'b1111; wdata = b;       end
            endcase
        end else if (align_store[ST_SWR]) begin
            // swr writes the low-order bytes of B into the lanes from a upward
            case (a)
                2'd0:    begin wstrb = 4'b1111; wdata = b;       end
                2'd1:    begin wstrb = 4'b1110; wdata = b << 8;  end
                2'd2:    begin wstrb = 4'b1100; wdata = b << 16; end
                default: begin wstrb = 4'b1000; wdata = b << 24; end
            endcase
        end
    end

endmodule

// File: rtl/ma_stage.sv
// Memory-access pipeline stage between EX and WB; issues one word-aligned data request per load/store.
// Latency: 1 cycle for non-memory ops; memory ops leave on the data_addr_ok edge (>= 1 cycle).
// Backpressure: holds while WB_enable is low or the address is not accepted; MA_enable gates EX.
// Ports: clk, rst_p (sync, active-high); EX side EX_ready/MA_enable + *_in fields;
//        WB side WB_enable/MA_ready + *_out fields; dbus (ma_stage_if.master) to the interlayer;
//        valid_out for hazard logic. Optional MA_ADDR_EXC_EN adds exc_out/badvaddr_out and
//        suppresses requests for misaligned lw/sw/lh/lhu/sh.
module ma_stage
    import ma_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst_p,

    input  logic               EX_ready,
    output logic               MA_enable,
    input  logic [31:0]        rf_B_in,
    input  logic [31:0]        alu_res_in,
    input  logic [31:0]        EX_PC,
    input  logic [4:0]         rf_waddr_in,
    input  logic [2:0]         rf_wdata_src_in,
    input  logic               rf_wen_in,
    input  logic               mem_read_in,
    input  logic [LOAD_W-1:0]  align_load_in,
    input  logic               mem_write_in,
    input  logic [STORE_W-1:0] align_store_in,

    input  logic               WB_enable,
    output logic               MA_ready,
    output logic [31:0]        rf_B_out,
    output logic [31:0]        alu_res_out,
    output logic [31:0]        MA_PC,
    output logic [4:0]         rf_waddr_out,
    output logic [2:0]         rf_wdata_src_out,
    output logic               rf_wen_out,
    output logic               mem_read_out,
    output logic [LOAD_W-1:0]  align_load_out,

    ma_stage_if.master         dbus,

    output logic               valid_out
`ifdef MA_ADDR_EXC_EN
    ,
    output logic               exc_out,
    output logic [31:0]        badvaddr_out
`endif
);

    ma_inst_t  inst_q;
    logic      valid_q;
    logic      req_done_q;   // this instruction's address was already accepted
    ma_state_e state_q, state_d;

    logic       comming, leaving;
    logic       is_mem, misalign, mem_go, req_cond, req;
    logic [1:0] a;
    logic [3:0] st_wstrb;
    logic [31:0] st_wdata;

    assign a      = inst_q.alu_res[1:0];
    assign is_mem = inst_q.mem_read || inst_q.mem_write;

`ifdef MA_ADDR_EXC_EN
    // Only the naturally aligned accesses can fault; lwl/lwr/swl/swr never do.
    assign misalign = ((inst_q.align_load[LD_LW] || inst_q.align_store[ST_SW]) && (a != 2'd0))
                   || ((inst_q.align_load[LD_LH] || inst_q.align_load[LD_LHU]
                        || inst_q.align_store[ST_SH]) && a[0]);
    assign exc_out      = valid_q && misalign;
    assign badvaddr_out = inst_q.alu_res;
`else
    assign misalign = 1'b0;
`endif

    // A faulting access is retired as a plain non-memory op.
    assign mem_go   = is_mem && !misalign;
    assign req_cond = valid_q && mem_go && WB_enable && !req_done_q;

    // Request FSM: the request goes out combinationally in the first cycle it is
    // possible, so an immediate addr_ok never visits REQ.
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        case (state_q)
            MA_IDLE: begin
                if (req_cond) begin
                    req = 1'b1;
                    if (!dbus.data_addr_ok) state_d = MA_REQ;
                end
            end
            MA_REQ: begin
                req = 1'b1;
                if (dbus.data_addr_ok) state_d = MA_IDLE;
            end
            default: state_d = MA_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_p) state_q <= MA_IDLE;
        else       state_q <= state_d;
    end

    // Leaving on the address-accept edge hands the load to WB before its data can return.
    assign leaving   = valid_q && WB_enable
                    && (!mem_go || req_done_q || (req && dbus.data_addr_ok));
    assign MA_enable = !valid_q || leaving;
    assign MA_ready  = leaving;
    assign comming   = MA_enable && EX_ready;

    always_ff @(posedge clk) begin
        if (rst_p) begin
            inst_q     <= '0;
            valid_q    <= 1'b0;
            req_done_q <= 1'b0;
        end else begin
            if (comming) begin
                inst_q <= '{pc:           EX_PC,
                            rf_b:         rf_B_in,
                            alu_res:      alu_res_in,
                            rf_waddr:     rf_waddr_in,
                            rf_wdata_src: rf_wdata_src_in,
                            rf_wen:       rf_wen_in,
                            mem_read:     mem_read_in,
                            align_load:   align_load_in,
                            mem_write:    mem_write_in,
                            align_store:  align_store_in};
                valid_q    <= 1'b1;
                req_done_q <= 1'b0;
            end else begin
                if (leaving) valid_q <= 1'b0;
                // Guards against re-issuing if the address was taken while WB stalled.
                if (req && dbus.data_addr_ok && !leaving) req_done_q <= 1'b1;
            end
        end
    end

    ma_store_align u_store_align (
        .align_store (inst_q.mem_write ? inst_q.align_store : {STORE_W{1'b0}}),
        .a           (a),
        .b           (inst_q.rf_b),
        .wstrb       (st_wstrb),
        .wdata       (st_wdata)
    );

    assign dbus.data_req   = req;
    assign dbus.data_wr    = inst_q.mem_write;
    assign dbus.data_addr  = word_addr(inst_q.alu_res);
    assign dbus.data_wstrb = st_wstrb;
    assign dbus.data_wdata = st_wdata;

    assign valid_out        = valid_q;
    assign rf_B_out         = inst_q.rf_b;
    assign alu_res_out      = inst_q.alu_res;
    assign MA_PC            = inst_q.pc;
    assign rf_waddr_out     = inst_q.rf_waddr;
    assign rf_wdata_src_out = inst_q.rf_wdata_src;
    assign rf_wen_out       = inst_q.rf_wen && !misalign;
    assign mem_read_out     = inst_q.mem_read && !misalign;
    assign align_load_out   = inst_q.align_load;

endmodule

// File: tb/tb_ma_stage.sv
// Bench for ma_stage: vector table plus scoreboard, interlayer model with programmable addr_ok delay.
// Latency: checks per-instruction residency and request length against the table.
// Backpressure: drives WB_enable stalls and delayed data_addr_ok.
module tb_ma_stage;
    import ma_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_p;
    always #5 clk = ~clk;

    logic               EX_ready, MA_enable, WB_enable, MA_ready, valid_out;
    logic [31:0]        rf_B_in, alu_res_in, EX_PC, rf_B_out, alu_res_out, MA_PC;
    logic [4:0]         rf_waddr_in, rf_waddr_out;
    logic [2:0]         rf_wdata_src_in, rf_wdata_src_out;
    logic               rf_wen_in, rf_wen_out, mem_read_in, mem_read_out, mem_write_in;
    logic [LOAD_W-1:0]  align_load_in, align_load_out;
    logic [STORE_W-1:0] align_store_in;
`ifdef MA_ADDR_EXC_EN
    logic               exc_out;
    logic [31:0]        badvaddr_out;
`endif

    ma_stage_if dbus();

    ma_stage dut (
        .clk(clk), .rst_p(rst_p),
        .EX_ready(EX_ready), .MA_enable(MA_enable),
        .rf_B_in(rf_B_in), .alu_res_in(alu_res_in), .EX_PC(EX_PC),
        .rf_waddr_in(rf_waddr_in), .rf_wdata_src_in(rf_wdata_src_in), .rf_wen_in(rf_wen_in),
        .mem_read_in(mem_read_in), .align_load_in(align_load_in),
        .mem_write_in(mem_write_in), .align_store_in(align_store_in),
        .WB_enable(WB_enable), .MA_ready(MA_ready),
        .rf_B_out(rf_B_out), .alu_res_out(alu_res_out), .MA_PC(MA_PC),
        .rf_waddr_out(rf_waddr_out), .rf_wdata_src_out(rf_wdata_src_out),
        .rf_wen_out(rf_wen_out), .mem_read_out(mem_read_out), .align_load_out(align_load_out),
        .dbus(dbus),
        .valid_out(valid_out)
`ifdef MA_ADDR_EXC_EN
        , .exc_out(exc_out), .badvaddr_out(badvaddr_out)
`endif
    );

    typedef struct {
        string       name;
        logic        mr;
        logic [6:0]  ld;
        logic        mw;
        logic [4:0]  st;
        logic        wen;
        logic [31:0] alu;
        logic [31:0] b;
        int          ok_delay;
        int          wb_stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        int          exp_cycles;
        logic        exp_exc;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] pc, alu, b;
        logic [4:0]  waddr;
        logic [2:0]  src;
        logic        wen, mem_read;
        logic [6:0]  ld;
        logic        req, wr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          cycles;
        int          req_cycles;
        logic        exc;
    } exp_t;

    exp_t sb_q[$];
    exp_t popped;
    vec_t vecs[$];

    int n_cmp = 0, n_err = 0;
    int ok_delay = 0, req_wait = 0, front_cycles = 0, front_req = 0, cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event happened, expected none", name);
    endtask

    function automatic vec_t mk(input string name, input logic mr, input logic [6:0] ld,
                                input logic mw, input logic [4:0] st, input logic wen,
                                input logic [31:0] alu, input logic [31:0] b,
                                input int okd, input int stall, input logic ereq,
                                input logic [31:0] eaddr, input logic [3:0] ewstrb,
                                input logic [31:0] ewdata, input int ecyc, input logic eexc);
        vec_t v;
        v.name = name; v.mr = mr; v.ld = ld; v.mw = mw; v.st = st; v.wen = wen;
        v.alu = alu; v.b = b; v.ok_delay = okd; v.wb_stall = stall; v.exp_req = ereq;
        v.exp_addr = eaddr; v.exp_wstrb = ewstrb; v.exp_wdata = ewdata;
        v.exp_cycles = ecyc; v.exp_exc = eexc;
        return v;
    endfunction

    // Interlayer model and output monitor: addr_ok is raised once the request has
    // waited ok_delay cycles; outputs are sampled 1 time unit after the falling edge.
    always @(negedge clk) begin
        dbus.data_addr_ok = dbus.data_req && (req_wait >= ok_delay);
        #1;
        if (valid_out) front_cycles++;
        if (dbus.data_req === 1'b1) begin
            front_req++;
            if (sb_q.size() == 0) flag("req_without_instruction");
            else begin
                check({sb_q[0].name, "_req_allowed"}, 1'b1, sb_q[0].req);
                check({sb_q[0].name, "_wr_addr_strb_data"},
                      {dbus.data_wr, dbus.data_addr, dbus.data_wstrb, dbus.data_wdata},
                      {sb_q[0].wr, sb_q[0].addr, sb_q[0].wstrb, sb_q[0].wdata});
            end
        end
        if (WB_enable === 1'b0 && valid_out === 1'b1)
            check("req_during_wb_stall", dbus.data_req, 1'b0);
        if (MA_ready === 1'b1) begin
            if (sb_q.size() == 0) flag("ready_without_instruction");
            else begin
                popped = sb_q.pop_front();
                check({popped.name, "_passthru"},
                      {MA_PC, alu_res_out, rf_B_out, rf_waddr_out, rf_wdata_src_out,
                       rf_wen_out, mem_read_out, align_load_out},
                      {popped.pc, popped.alu, popped.b, popped.waddr, popped.src,
                       popped.wen, popped.mem_read, popped.ld});
                check({popped.name, "_cycles_in_ma"}, front_cycles, popped.cycles);
                check({popped.name, "_req_cycles"}, front_req, popped.req_cycles);
`ifdef MA_ADDR_EXC_EN
                check({popped.name, "_exc"}, exc_out, popped.exc);
                if (popped.exc) check({popped.name, "_badvaddr"}, badvaddr_out, popped.alu);
`endif
            end
            front_cycles = 0;
            front_req    = 0;
        end
        if (dbus.data_req === 1'b1 && dbus.data_addr_ok) req_wait = 0;
        else if (dbus.data_req === 1'b1) req_wait++;
    end

    // Presents one instruction from posedge+1 until MA takes it; pushes its expectation.
    task automatic send(input vec_t v, input int idx, output int cap_cyc);
        int tries = 0;
        exp_t e;
        EX_PC           = 32'hBFC0_0000 + 32'(idx) * 4;
        rf_B_in         = v.b;
        alu_res_in      = v.alu;
        rf_waddr_in     = 5'(idx + 1);
        rf_wdata_src_in = 3'(idx);
        rf_wen_in       = v.wen;
        mem_read_in     = v.mr;
        align_load_in   = v.ld;
        mem_write_in    = v.mw;
        align_store_in  = v.st;
        EX_ready        = 1'b1;
        cap_cyc         = -1;
        while (tries < 50) begin
            @(negedge clk); #2;
            if (MA_enable === 1'b1) break;
            tries++;
        end
        if (tries >= 50) begin
            check({v.name, "_accept_timeout"}, MA_enable, 1'b1);
            EX_ready = 1'b0;
            return;
        end
        @(posedge clk); #1;
        EX_ready = 1'b0;
        cap_cyc  = cyc;
        e.name = v.name; e.pc = EX_PC; e.alu = v.alu; e.b = v.b;
        e.waddr = rf_waddr_in; e.src = rf_wdata_src_in;
        e.wen = v.exp_exc ? 1'b0 : v.wen;
        e.mem_read = v.exp_exc ? 1'b0 : v.mr;
        e.ld = v.ld; e.req = v.exp_req; e.wr = v.mw; e.addr = v.exp_addr;
        e.wstrb = v.exp_wstrb; e.wdata = v.exp_wdata; e.cycles = v.exp_cycles;
        e.req_cycles = v.exp_req ? v.ok_delay + 1 : 0;
        e.exc = v.exp_exc;
        sb_q.push_back(e);
    endtask

    task automatic wait_empty(input string name);
        int t = 0;
        while (sb_q.size() != 0 && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        if (sb_q.size() != 0) begin
            check({name, "_drain_timeout"}, sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c1, c2;
        rst_p = 1'b1; EX_ready = 1'b0; WB_enable = 1'b1;
        rf_B_in = '0; alu_res_in = '0; EX_PC = '0; rf_waddr_in = '0; rf_wdata_src_in = '0;
        rf_wen_in = 1'b0; mem_read_in = 1'b0; align_load_in = '0;
        mem_write_in = 1'b0; align_store_in = '0;

        repeat (2) @(posedge clk);
        #1 rst_p = 1'b0;
        @(negedge clk); #2;
        check("rst_MA_enable", MA_enable, 1'b1);
        check("rst_MA_ready", MA_ready, 1'b0);
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_data_req", dbus.data_req, 1'b0);
        check("rst_data_bus", {dbus.data_wr, dbus.data_addr, dbus.data_wstrb, dbus.data_wdata}, '0);
        check("rst_pass_outs", {alu_res_out, MA_PC, rf_B_out, rf_wen_out, mem_read_out}, '0);
        @(posedge clk); #1;

        //            name            mr ld          mw st        wen alu           b             okd stl req addr          wstrb    wdata         cyc exc
        vecs.push_back(mk("add",          0, 7'b0000000, 0, 5'b00000, 1, 32'h12345678, 32'hDEADBEEF, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        1, 0));
        vecs.push_back(mk("sb_a3",        0, 7'b0000000, 1, 5'b01000, 0, 32'h00001003, 32'h000000AB, 0, 0, 1, 32'h00001000, 4'b1000, 32'hABABABAB, 1, 0));
        vecs.push_back(mk("lw_wait3",     1, 7'b1000000, 0, 5'b00000, 1, 32'h00002000, 32'h55555555, 3, 0, 1, 32'h00002000, 4'b0000, 32'h0,        4, 0));
        vecs.push_back(mk("swr_a2",       0, 7'b0000000, 1, 5'b00001, 0, 32'h00003002, 32'h11223344, 0, 0, 1, 32'h00003000, 4'b1100, 32'h33440000, 1, 0));
        vecs.push_back(mk("swl_a1",       0, 7'b0000000, 1, 5'b00010, 0, 32'h00003001, 32'h11223344, 0, 0, 1, 32'h00003000, 4'b0011, 32'h00001122, 1, 0));
        vecs.push_back(mk("swl_a3",       0, 7'b0000000, 1, 5'b00010, 0, 32'h0000300B, 32'h11223344, 0, 0, 1, 32'h00003008, 4'b1111, 32'h11223344, 1, 0));
        vecs.push_back(mk("swl_a0",       0, 7'b0000000, 1, 5'b00010, 0, 32'h00003010, 32'h11223344, 0, 0, 1, 32'h00003010, 4'b0001, 32'h00000011, 1, 0));
        vecs.push_back(mk("swr_a3",       0, 7'b0000000, 1, 5'b00001, 0, 32'h00003017, 32'h11223344, 0, 0, 1, 32'h00003014, 4'b1000, 32'h44000000, 1, 0));
        vecs.push_back(mk("swr_a1",       0, 7'b0000000, 1, 5'b00001, 0, 32'h00003019, 32'h11223344, 0, 0, 1, 32'h00003018, 4'b1110, 32'h22334400, 1, 0));
        vecs.push_back(mk("sh_a2_wait1",  0, 7'b0000000, 1, 5'b00100, 0, 32'h00004002, 32'hCAFEBEEF, 1, 0, 1, 32'h00004000, 4'b1100, 32'hBEEFBEEF, 2, 0));
        vecs.push_back(mk("sh_a0",        0, 7'b0000000, 1, 5'b00100, 0, 32'h00004004, 32'hCAFEBEEF, 0, 0, 1, 32'h00004004, 4'b0011, 32'hBEEFBEEF, 1, 0));
        vecs.push_back(mk("sw",           0, 7'b0000000, 1, 5'b10000, 0, 32'h00005000, 32'h89ABCDEF, 0, 0, 1, 32'h00005000, 4'b1111, 32'h89ABCDEF, 1, 0));
        vecs.push_back(mk("sb_a0",        0, 7'b0000000, 1, 5'b01000, 0, 32'h00008000, 32'h0000005A, 0, 0, 1, 32'h00008000, 4'b0001, 32'h5A5A5A5A, 1, 0));
        vecs.push_back(mk("lw_wbstall2",  1, 7'b1000000, 0, 5'b00000, 1, 32'h00006004, 32'h0,        0, 2, 1, 32'h00006004, 4'b0000, 32'h0,        3, 0));
        vecs.push_back(mk("lb_a3",        1, 7'b0100000, 0, 5'b00000, 1, 32'h00009003, 32'h0,        0, 0, 1, 32'h00009000, 4'b0000, 32'h0,        1, 0));
`ifdef MA_ADDR_EXC_EN
        vecs.push_back(mk("lw_misalign",  1, 7'b1000000, 0, 5'b00000, 1, 32'h00001002, 32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        1, 1));
        vecs.push_back(mk("sh_misalign",  0, 7'b0000000, 1, 5'b00100, 0, 32'h00001003, 32'h1234,     0, 0, 0, 32'h0,        4'b0000, 32'h0,        1, 1));
        vecs.push_back(mk("lwl_a2_ok",    1, 7'b0000010, 0, 5'b00000, 1, 32'h00001002, 32'h0,        0, 0, 1, 32'h00001000, 4'b0000, 32'h0,        1, 0));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            ok_delay = vecs[i].ok_delay;
            send(vecs[i], i, c1);
            if (vecs[i].wb_stall > 0) begin
                WB_enable = 1'b0;
                repeat (vecs[i].wb_stall) @(posedge clk);
                #1 WB_enable = 1'b1;
            end
            wait_empty(vecs[i].name);
        end

        // Back-to-back lw then sw: the sw must be captured on the lw's leaving edge.
        ok_delay = 0;
        send(mk("b2b_lw", 1, 7'b1000000, 0, 5'b00000, 1, 32'h0000A000, 32'h0,
                0, 0, 1, 32'h0000A000, 4'b0000, 32'h0, 1, 0), 100, c1);
        send(mk("b2b_sw", 0, 7'b0000000, 1, 5'b10000, 0, 32'h0000A004, 32'h01020304,
                0, 0, 1, 32'h0000A004, 4'b1111, 32'h01020304, 1, 0), 101, c2);
        check("b2b_capture_gap", c2 - c1, 1);
        wait_empty("b2b");

        // Reset while a request is outstanding.
        ok_delay = 1000;
        send(mk("midreset_lw", 1, 7'b1000000, 0, 5'b00000, 1, 32'h0000B000, 32'h0,
                0, 0, 1, 32'h0000B000, 4'b0000, 32'h0, 1, 0), 102, c1);
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        check("midreset_req_before", dbus.data_req, 1'b1);
        @(posedge clk); #1 rst_p = 1'b1;
        @(posedge clk); #1 rst_p = 1'b0;
        sb_q.delete();
        front_cycles = 0; front_req = 0; req_wait = 0; ok_delay = 0;
        @(negedge clk); #2;
        check("midreset_req_after", dbus.data_req, 1'b0);
        check("midreset_valid_after", valid_out, 1'b0);
        check("midreset_MA_enable", MA_enable, 1'b1);
        @(posedge clk); #1;
        send(mk("post_reset_add", 0, 7'b0000000, 0, 5'b00000, 1, 32'h0BADF00D, 32'h77,
                0, 0, 0, 32'h0, 4'b0000, 32'h0, 1, 0), 103, c1);
        wait_empty("post_reset");

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ma_stage.md
# ma_stage

Memory-access pipeline stage between EX and WB. It latches one instruction per valid/ready handshake and, for loads and stores, issues exactly one word-aligned request to the data interlayer. Store bytes are aligned and strobed here. The stage hands the instruction to WB on the same edge the interlayer accepts the address, so WB always owns the load before its data returns.

## Interface
Parameters: none.

- clk  in  1  clock; all state updates on the rising edge.
- rst_p  in  1  synchronous, active-high reset.
- EX_ready  in  1  EX has an instruction to hand over.
- MA_enable  out  1  MA can accept this cycle.
- rf_B_in, alu_res_in, EX_PC  in  32 each  store source / register B, ALU result (effective address), PC.
- rf_waddr_in  in  5; rf_wdata_src_in  in  3; rf_wen_in  in  1  writeback control, passed through.
- mem_read_in  in  1; align_load_in  in  7  one-hot {lw,lb,lbu,lh,lhu,lwl,lwr}.
- mem_write_in  in  1; align_store_in  in  5  one-hot {sw,sb,sh,swl,swr}.
- WB_enable  in  1  WB can accept.
- MA_ready  out  1  MA hands over this cycle.
- rf_B_out, alu_res_out, MA_PC  out  32 each; rf_waddr_out  out  5; rf_wdata_src_out  out  3; rf_wen_out  out  1; mem_read_out  out  1; align_load_out  out  7.
- data_req  out  1; data_wr  out  1; data_wstrb  out  4; data_addr  out  32; data_wdata  out  32  interlayer request.
- data_addr_ok  in  1  interlayer accepts the request this cycle.
- valid_out  out  1  stage holds an instruction; used by forwarding and hazard logic.
- exc_out  out  1; badvaddr_out  out  32  address error. Present only with MA_ADDR_EXC_EN.

## Operation
- comming = MA_enable && EX_ready. On comming, all *_in fields and EX_PC are captured. valid is set on comming and cleared on leaving when there is no new comming.
- is_mem = mem_read || mem_write.
- FSM has two states:
  - IDLE: no request in flight.
  - REQ: data_req is asserted.
- Transitions:
  - IDLE→REQ when valid && is_mem && WB_enable && no request has been issued yet for this instruction.
  - REQ→IDLE on data_addr_ok.
- data_req is combinational and is asserted in both of these cases:
  - state==REQ.
  - IDLE with the entry condition true. The request is issued the same cycle it becomes possible.
- Once asserted, data_req and all data_* outputs stay stable until data_addr_ok. This holds because WB_enable cannot fall while MA is in REQ: WB has no other feeder.
- leaving = valid && WB_enable && (!is_mem || data_addr_ok). MA_ready = leaving. MA_enable = !valid || leaving.
- data_wr = mem_write. data_addr = {alu_res[31:2], 2'b00}. Loads always fetch the full word; WB does byte extraction.
- Store alignment uses a = alu_res[1:0] and B = rf_B:
  - sw: wstrb 1111, wdata B.
  - sb: wstrb = 1<<a, wdata {4{B[7:0]}}.
  - sh: wstrb a[1] ? 1100 : 0011, wdata {2{B[15:0]}}.
  - swl, by a = 0/1/2/3:
    - wstrb 0001 / 0011 / 0111 / 1111.
    - wdata B>>24 / B>>16 / B>>8 / B.
  - swr, by a = 0/1/2/3:
    - wstrb 1111 / 1110 / 1100 / 1000.
    - wdata B / B<<8 / B<<16 / B<<24.
- During loads, wstrb=0000 and wdata=0.

## Timing
- Reset: valid=0, state=IDLE, and every output is 0, except MA_enable=1.
- Non-memory instruction: 1 cycle in MA when WB_enable is high.
- Memory instruction: at least 1 cycle, i.e. addr_ok in the same cycle as the request. Each cycle without addr_ok adds one cycle.
- The instruction enters WB on the same edge as the address handshake. data_ok therefore never precedes WB ownership.
- WB_enable low with a pending memory op: no request is issued and the stage holds.
- Simultaneous leaving and comming: the new instruction is captured and valid stays 1.
- Reset mid-request: the FSM returns to IDLE and data_req drops the next cycle. The interlayer is reset together with the stage.

## Configuration
- MA_ADDR_EXC_EN defined:
  - A misaligned lw/sw (a≠0) or lh/lhu/sh (a[0]=1) issues no request.
  - Such an instruction leaves as a non-memory op with rf_wen_out=0, exc_out=1, badvaddr_out=alu_res.
  - lwl/lwr/swl/swr are never flagged.
- MA_ADDR_EXC_EN undefined: no check is made, and exc_out/badvaddr_out are absent.

## Structure
- Shared package holds:
  - Bit indices of align_load and align_store.
  - The FSM state encoding.
  - Load/store one-hot widths.
- One combinational sub-module, ma_store_align: (align_store, a, B) → (wstrb, wdata).

## Test plan
- add, WB_enable=1: MA_ready high 1 cycle after entry, alu_res_out and rf_waddr_out pass through, data_req stays 0.
- sb, alu_res=0x1003, B=0x000000AB, addr_ok same cycle: data_addr=0x1000, wstrb=1000, wdata=0xABABABAB, leaves in 1 cycle.
- lw with addr_ok delayed 3 cycles: data_req high and stable 4 cycles, MA_ready only in the 4th, mem_read_out=1.
- swr with a=2, B=0x11223344: wstrb=1100, wdata=0x33440000. swl with a=1: wstrb=0011, wdata=0x00001122.
- WB_enable=0 for 2 cycles with a load present: data_req=0. It rises in the cycle WB_enable rises, then a back-to-back lw→sw pair follows with no bubble beyond the handshakes.
- With MA_ADDR_EXC_EN: lw at 0x1002 → no data_req, exc_out=1, badvaddr_out=0x1002, rf_wen_out=0.
